start_fifo_srl_ctrl: RTL and testbench
======================================

// Module: start_fifo_srl_ctrl
// PURPOSE
//   Control logic for the SRL-based start-token FIFOs between dataflow processes (e.g. PE start chains).
//   Owns occupancy, read pointer and ap_fifo-style full_n/empty_n handshakes.
//   Drives we/addr of an external SRL storage instance and returns its dout as if_dout.
//   One instance per start FIFO; sits between the producer's start_write and the consumer's start_read.
// PARAMETERS
//   DATA_WIDTH  1  token width, passed through to the storage
//   ADDR_WIDTH  1  SRL address width; must satisfy 2**ADDR_WIDTH >= DEPTH
//   DEPTH       2  FIFO capacity in entries (>=2)
//   AF_MARGIN   1  almost_full_n deasserts when count >= DEPTH-AF_MARGIN (0 < AF_MARGIN < DEPTH)
// PORTS
//   clk            in   1           clock, all logic on rising edge
//   reset_n        in   1           asynchronous, active-low reset
//   if_write_ce    in   1           producer write enable qualifier
//   if_write       in   1           producer write request
//   if_din         in   DATA_WIDTH  token to push
//   if_full_n      out  1           1 = space available
//   if_almost_full_n out 1          0 = count >= DEPTH-AF_MARGIN
//   if_read_ce     in   1           consumer read enable qualifier
//   if_read        in   1           consumer read request
//   if_dout        out  DATA_WIDTH  head token (valid while if_empty_n=1)
//   if_empty_n     out  1           1 = at least one token stored
//   sreg_we        out  1           storage shift enable (= push)
//   sreg_addr      out  ADDR_WIDTH  storage read address (head entry)
//   sreg_din       out  DATA_WIDTH  = if_din
//   sreg_dout      in   DATA_WIDTH  storage read data, combinational from sreg_addr
//   occupancy      out  ADDR_WIDTH+1 [START_FIFO_OCC_EN only] current count
//   err_sticky     out  1           [START_FIFO_OCC_EN only] overflow/underflow flag
//   err_clr        in   1           [START_FIFO_OCC_EN only] clears err_sticky
// BEHAVIOUR
//   - push = if_write_ce & if_write & if_full_n; pop = if_read_ce & if_read & if_empty_n.
//   - Internal count cnt[ADDR_WIDTH:0], range 0..DEPTH. Registered flags:
//     if_empty_n = (cnt!=0), if_full_n = (cnt!=DEPTH), if_almost_full_n = (cnt < DEPTH-AF_MARGIN).
//   - Reset (async assert, sync release): cnt=0, sreg_addr=0, if_empty_n=0, if_full_n=1,
//     if_almost_full_n=1, occupancy=0, err_sticky=0. Storage contents are don't-care.
//   - Push only: cnt+1; sreg_addr+1 unless cnt was 0 (addr stays 0).
//   - Pop only: cnt-1; sreg_addr-1 unless cnt was 1 (addr stays 0).
//   - Push and pop same cycle (needs cnt>=1): cnt, sreg_addr, flags unchanged; storage shifts.
//   - Write while full or read while empty: ignored, state unchanged (no wrap-around).
//   - Latency: token written in cycle N visible on if_dout, if_empty_n=1 in cycle N+1.
//   - Flags update on the edge after the causing push/pop; no combinational in->flag paths.
//   - sreg_addr invariant: sreg_addr = (cnt==0) ? 0 : cnt-1.
//   - if_dout = sreg_dout (combinational pass-through).
//   - Reset asserted mid-traffic: all state returns to reset values immediately; in-flight tokens lost.
// CONFIGURATION
//   START_FIFO_OCC_EN defined: occupancy = cnt (registered); err_sticky sets on
//     if_write_ce&if_write&!if_full_n or if_read_ce&if_read&!if_empty_n, holds until err_clr=1
//     (set wins over clear in the same cycle).
//   Undefined: occupancy, err_sticky, err_clr ports and logic are absent; behaviour otherwise identical.
// TESTING
//   1. Reset, DEPTH=2: no traffic -> if_empty_n=0, if_full_n=1, sreg_addr=0 for 10 cycles.
//   2. Push 0xA,0xB (DATA_WIDTH=4) -> if_full_n=0 after 2nd edge, sreg_addr=1; pops return A then B, then if_empty_n=0.
//   3. DEPTH=4, AF_MARGIN=1: push 3 -> if_almost_full_n=0 on 3rd edge; if_full_n still 1.
//   4. cnt=1, push+pop same cycle -> cnt=1, sreg_addr=0, if_dout = newly pushed token.
//   5. Full FIFO, extra write -> state unchanged; with START_FIFO_OCC_EN err_sticky=1 until err_clr.
//   6. cnt=2, assert reset_n=0 mid-cycle -> flags reset asynchronously before next clk edge.

Source files
------------

// File: rtl/start_fifo_srl_ctrl.sv
// Start-token FIFO controller driving an external SRL: occupancy, head address and ap_fifo handshakes.
// Optional START_FIFO_OCC_EN adds the occupancy/err_sticky/err_clr debug ports.
module start_fifo_srl_ctrl #(
  parameter int unsigned DATA_WIDTH = 1,
  parameter int unsigned ADDR_WIDTH = 1,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned AF_MARGIN  = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  output logic                  if_almost_full_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic                  sreg_we,
  output logic [ADDR_WIDTH-1:0] sreg_addr,
  output logic [DATA_WIDTH-1:0] sreg_din,
  input  logic [DATA_WIDTH-1:0] sreg_dout
`ifdef START_FIFO_OCC_EN
  ,
  output logic [ADDR_WIDTH:0]   occupancy,
  output logic                  err_sticky,
  input  logic                  err_clr
`endif
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(DEPTH - AF_MARGIN);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  empty_n_q, empty_n_d;
  logic                  full_n_q, full_n_d;
  logic                  afull_n_q, afull_n_d;
  logic                  push_c, pop_c;

  assign push_c = if_write_ce & if_write & full_n_q;
  assign pop_c  = if_read_ce & if_read & empty_n_q;

  // Head sits at cnt-1 because the SRL shifts new tokens in at address 0.
  always_comb begin
    cnt_d  = cnt_q;
    addr_d = addr_q;
    unique case ({push_c, pop_c})
      2'b10: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q != '0) addr_d = addr_q + ADDR_WIDTH'(1);
      end
      2'b01: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q != CNT_W'(1)) addr_d = addr_q - ADDR_WIDTH'(1);
      end
      default: ;
    endcase
    empty_n_d = (cnt_d != '0);
    full_n_d  = (cnt_d != FULL_CNT);
    afull_n_d = (cnt_d < AF_CNT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      addr_q    <= '0;
      empty_n_q <= 1'b0;
      full_n_q  <= 1'b1;
      afull_n_q <= 1'b1;
    end else begin
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      empty_n_q <= empty_n_d;
      full_n_q  <= full_n_d;
      afull_n_q <= afull_n_d;
    end
  end

  assign if_empty_n       = empty_n_q;
  assign if_full_n        = full_n_q;
  assign if_almost_full_n = afull_n_q;
  assign sreg_addr        = addr_q;
  assign sreg_we          = push_c;
  assign sreg_din         = if_din;
  assign if_dout          = sreg_dout;

`ifdef START_FIFO_OCC_EN
  logic err_q, err_d;
  logic err_ev_c;

  // Rejected write or read; a new error outranks a simultaneous clear.
  assign err_ev_c = (if_write_ce & if_write & ~full_n_q) | (if_read_ce & if_read & ~empty_n_q);

  always_comb begin
    err_d = err_q;
    if (err_clr)  err_d = 1'b0;
    if (err_ev_c) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end

  assign occupancy  = cnt_q;
  assign err_sticky = err_q;
`endif

endmodule

// File: tb/tb_start_fifo_srl_ctrl.sv
// Randomized bench for start_fifo_srl_ctrl against a queue-based FIFO model with an SRL storage stand-in.
module tb_start_fifo_srl_ctrl;

  localparam int unsigned DW = 4;
  localparam int unsigned AW = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AFM = 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          if_write_ce, if_write, if_read_ce, if_read;
  logic [DW-1:0] if_din;
  logic          if_full_n, if_almost_full_n, if_empty_n;
  logic [DW-1:0] if_dout;
  logic          sreg_we;
  logic [AW-1:0] sreg_addr;
  logic [DW-1:0] sreg_din, sreg_dout;
  logic          err_clr;
`ifdef START_FIFO_OCC_EN
  logic [AW:0]   occupancy;
  logic          err_sticky;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] q[$];
  logic          m_err = 1'b0;

  always #5 clk = ~clk;

  start_fifo_srl_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .AF_MARGIN(AFM)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .if_write_ce(if_write_ce), .if_write(if_write), .if_din(if_din),
    .if_full_n(if_full_n), .if_almost_full_n(if_almost_full_n),
    .if_read_ce(if_read_ce), .if_read(if_read), .if_dout(if_dout), .if_empty_n(if_empty_n),
    .sreg_we(sreg_we), .sreg_addr(sreg_addr), .sreg_din(sreg_din), .sreg_dout(sreg_dout)
`ifdef START_FIFO_OCC_EN
    , .occupancy(occupancy), .err_sticky(err_sticky), .err_clr(err_clr)
`endif
  );

  // Shift-register storage: new entry at 0, older entries move up.
  logic [DW-1:0] srl [2**AW];
  always @(posedge clk) begin
    if (sreg_we) begin
      for (int i = 2**AW - 1; i > 0; i--) srl[i] <= srl[i-1];
      srl[0] <= sreg_din;
    end
  end
  assign sreg_dout = srl[sreg_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_state();
    int n;
    n = q.size();
    check("empty_n", 32'(if_empty_n), 32'(n != 0));
    check("full_n", 32'(if_full_n), 32'(n != DEPTH));
    check("almost_full_n", 32'(if_almost_full_n), 32'(n < DEPTH - AFM));
    check("sreg_addr", 32'(sreg_addr), (n == 0) ? 32'd0 : 32'(n - 1));
    if (n != 0) check("dout", 32'(if_dout), 32'(q[0]));
`ifdef START_FIFO_OCC_EN
    check("occupancy", 32'(occupancy), 32'(n));
    check("err_sticky", 32'(err_sticky), 32'(m_err));
`endif
  endtask

  // Called just after a falling edge: drive one cycle of stimulus, advance the model, check next state.
  task automatic step(input logic wce, input logic wr, input logic [DW-1:0] din,
                      input logic rce, input logic rd, input logic clr);
    logic push, pop;
    if_write_ce = wce; if_write = wr; if_din = din;
    if_read_ce = rce; if_read = rd; err_clr = clr;
    #1;
    push = wce & wr & (q.size() != DEPTH);
    pop  = rce & rd & (q.size() != 0);
    check("sreg_we", 32'(sreg_we), 32'(push));
    check("sreg_din", 32'(sreg_din), 32'(din));
    if ((wce & wr & !push) | (rce & rd & !pop)) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
    if (pop)  void'(q.pop_front());
    if (push) q.push_back(din);
    @(negedge clk);
    check_state();
  endtask

  initial begin
    reset_n = 1'b0;
    if_write_ce = 0; if_write = 0; if_din = '0; if_read_ce = 0; if_read = 0; err_clr = 0;
    repeat (3) @(negedge clk);
    check_state();
    reset_n = 1'b1;
    // Idle after reset
    repeat (10) step(0, 0, '0, 0, 0, 0);

    // Two tokens in, come out in order
    step(1, 1, 4'hA, 0, 0, 0);
    step(1, 1, 4'hB, 0, 0, 0);
    step(0, 0, '0, 1, 1, 0);
    step(0, 0, '0, 1, 1, 0);
    step(0, 0, '0, 1, 1, 0);   // read while empty

    // Fill to almost full then full, extra write rejected, then clear error
    step(1, 1, 4'h1, 0, 0, 0);
    step(1, 1, 4'h2, 0, 0, 0);
    step(1, 1, 4'h3, 0, 0, 0);
    step(1, 1, 4'h4, 0, 0, 0);
    step(1, 1, 4'h5, 0, 0, 0);
    step(1, 1, 4'h6, 0, 0, 1); // new error wins over clear
    step(0, 0, '0, 0, 0, 1);
    step(1, 0, 4'h7, 0, 1, 0); // qualifiers alone do nothing
    repeat (4) step(0, 0, '0, 1, 1, 0);

    // Single entry, push and pop together
    step(1, 1, 4'h5, 0, 0, 0);
    step(1, 1, 4'h6, 1, 1, 0);
    step(1, 1, 4'h9, 1, 1, 0);
    step(0, 0, '0, 1, 1, 1);

    // Random traffic with alternating fill/drain bias
    for (int i = 0; i < 600; i++) begin
      int wp, rp;
      wp = ((i / 40) % 2 == 0) ? 80 : 30;
      rp = 110 - wp;
      step(($urandom % 100) < 90, ($urandom % 100) < wp, DW'($urandom),
           ($urandom % 100) < 90, ($urandom % 100) < rp, ($urandom % 8) == 0);
    end

    // Asynchronous reset mid-cycle with two tokens stored
    while (q.size() != 0) step(0, 0, '0, 1, 1, 0);
    step(1, 1, 4'hC, 0, 0, 0);
    step(1, 1, 4'hD, 0, 0, 0);
    if_write_ce = 0; if_write = 0; if_read_ce = 0; if_read = 0;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    q.delete();
    m_err = 1'b0;
    check_state();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) step(0, 0, '0, 0, 0, 0);
    step(1, 1, 4'hE, 0, 0, 0);
    step(0, 0, '0, 1, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
